// File: rtl/game_pkg.sv
// Shared types for the turn scheduler: board squares, turn states and small helpers.
package game_pkg;

  // Square index {row[5:3], col[2:0]}
  typedef logic [5:0] square_t;

  typedef enum logic [2:0] {
    IDLE,
    LOCAL_TURN,
    LOCAL_COMMIT,
    REMOTE_TURN,
    REMOTE_COMMIT,
    GAME_OVER
  } turn_state_t;

  localparam square_t    NULL_SQ      = 6'd0;
  localparam logic [9:0] TURN_CNT_MAX = 10'd1023;

  // A request whose source equals its destination is a cancelled pick, not a move
  function automatic logic is_move(input square_t from_sq, input square_t to_sq);
    return from_sq != to_sq;
  endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Move request / board update / UART send channels of the turn scheduler.
// master = scheduler side, slave = the surrounding game logic, board and encoder.
interface turn_scheduler_if;
  import game_pkg::*;

  logic    local_req;
  square_t local_from;
  square_t local_to;
  logic    local_ack;

  logic    remote_req;
  square_t remote_from;
  square_t remote_to;
  logic    remote_ack;

  logic    upd_valid;
  square_t upd_from;
  square_t upd_to;
  logic    upd_ready;

  logic    tx_valid;
  square_t tx_from;
  square_t tx_to;
  logic    tx_ready;

  modport master (
    input  local_req, local_from, local_to,
    output local_ack,
    input  remote_req, remote_from, remote_to,
    output remote_ack,
    output upd_valid, upd_from, upd_to,
    input  upd_ready,
    output tx_valid, tx_from, tx_to,
    input  tx_ready
  );

  modport slave (
    output local_req, local_from, local_to,
    input  local_ack,
    output remote_req, remote_from, remote_to,
    input  remote_ack,
    input  upd_valid, upd_from, upd_to,
    output upd_ready,
    input  tx_valid, tx_from, tx_to,
    output tx_ready
  );

endinterface

// File: rtl/turn_timer.sv
// Per-turn move timer: a 1 s prescaler feeding a seconds down-counter.
// Only instantiated when TURN_TIMER_EN is defined.
module turn_timer #(
  parameter int CLK_HZ      = 65_000_000,
  parameter int TURN_TIME_S = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reload,
  input  logic       run,
  output logic [7:0] time_left,
  output logic       expired
);

  localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [7:0]      TIME_INIT  = 8'(TURN_TIME_S);

  logic [PW-1:0] presc_reg;
  logic [7:0]    time_left_reg;
  logic          tick;

  assign tick      = run && (presc_reg == PRESC_LAST);
  // Fires in the cycle whose closing edge takes time_left from 1 to 0
  assign expired   = tick && (time_left_reg == 8'd1);
  assign time_left = time_left_reg;

  // Prescaler and seconds counter; reload restarts a full second from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg     <= '0;
      time_left_reg <= TIME_INIT;
    end else if (reload) begin
      presc_reg     <= '0;
      time_left_reg <= TIME_INIT;
    end else if (run) begin
      if (tick) begin
        presc_reg <= '0;
        if (time_left_reg != 8'd0) time_left_reg <= time_left_reg - 8'd1;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// Chess turn scheduler: alternates local and remote turns, owns the board write
// port, forwards committed local moves to the UART encoder and times each turn.
// Macro TURN_TIMER_EN enables the per-turn timer; without it time_left is fixed
// at TURN_TIME_S and the game never times out.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int CLK_HZ      = 65_000_000,
  parameter int TURN_TIME_S = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_player,
  turn_scheduler_if.master  bus,
  output logic              your_turn,
  output logic [7:0]        time_left,
  output logic [9:0]        turn_cnt,
  output logic              proto_err,
  output logic              game_over,
  output logic              local_lost
);

  localparam logic [7:0] TIME_INIT = 8'(TURN_TIME_S);

  turn_state_t state_reg, state_next;
  logic        local_ack_next, remote_ack_next, proto_err_next;
  logic        local_move, remote_move, expired, commit_done;

  logic        upd_valid_reg, tx_valid_reg, your_turn_reg;
  square_t     upd_from_reg, upd_to_reg, tx_from_reg, tx_to_reg;
  logic [9:0]  turn_cnt_reg;
  logic        game_over_reg, local_lost_reg;

  assign local_move  = bus.local_req && is_move(bus.local_from, bus.local_to);
  assign remote_move = bus.remote_req && is_move(bus.remote_from, bus.remote_to);

`ifdef TURN_TIMER_EN
  logic timer_reload, timer_run;

  assign timer_run    = (state_reg == LOCAL_TURN) || (state_reg == REMOTE_TURN);
  // Turn states are never entered from each other, so any change into one is an entry
  assign timer_reload = (state_next != state_reg) &&
                        ((state_next == LOCAL_TURN) || (state_next == REMOTE_TURN));

  turn_timer #(
    .CLK_HZ      (CLK_HZ),
    .TURN_TIME_S (TURN_TIME_S)
  ) u_turn_timer (
    .clk       (clk),
    .rst       (rst),
    .reload    (timer_reload),
    .run       (timer_run),
    .time_left (time_left),
    .expired   (expired)
  );
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(CLK_HZ);
  assign time_left  = TIME_INIT;
  assign expired    = 1'b0;
`endif

  // Next-state decode plus the same-cycle ack / protocol-error responses
  always_comb begin
    state_next      = state_reg;
    local_ack_next  = 1'b0;
    remote_ack_next = 1'b0;
    proto_err_next  = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (set_player) begin
            state_next     = LOCAL_TURN;
            proto_err_next = bus.remote_req;
          end else if (bus.remote_req) begin
            if (remote_move) begin
              remote_ack_next = 1'b1;
              state_next      = REMOTE_COMMIT;
            end else begin
              proto_err_next = 1'b1;
            end
          end
        end
        LOCAL_TURN: begin
          if (expired) begin
            state_next = GAME_OVER;
          end else begin
            if (bus.local_req) begin
              local_ack_next = 1'b1;
              if (local_move) state_next = LOCAL_COMMIT;
            end
            if (bus.remote_req) proto_err_next = 1'b1;
          end
        end
        LOCAL_COMMIT: begin
          if ((!upd_valid_reg || bus.upd_ready) && (!tx_valid_reg || bus.tx_ready))
            state_next = REMOTE_TURN;
        end
        REMOTE_TURN: begin
          if (expired) begin
            state_next = GAME_OVER;
          end else if (bus.remote_req) begin
            if (remote_move) begin
              remote_ack_next = 1'b1;
              state_next      = REMOTE_COMMIT;
            end else begin
              proto_err_next = 1'b1;
            end
          end
        end
        REMOTE_COMMIT: begin
          if (upd_valid_reg && bus.upd_ready) state_next = LOCAL_TURN;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  assign commit_done = ((state_reg == LOCAL_COMMIT)  && (state_next == REMOTE_TURN)) ||
                       ((state_reg == REMOTE_COMMIT) && (state_next == LOCAL_TURN));

  // State register and registered channel / status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      your_turn_reg  <= 1'b0;
      upd_valid_reg  <= 1'b0;
      upd_from_reg   <= NULL_SQ;
      upd_to_reg     <= NULL_SQ;
      tx_valid_reg   <= 1'b0;
      tx_from_reg    <= NULL_SQ;
      tx_to_reg      <= NULL_SQ;
      turn_cnt_reg   <= '0;
      game_over_reg  <= 1'b0;
      local_lost_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      your_turn_reg <= (state_next == LOCAL_TURN);

      if (local_ack_next && local_move) begin
        upd_valid_reg <= 1'b1;
        upd_from_reg  <= bus.local_from;
        upd_to_reg    <= bus.local_to;
        tx_valid_reg  <= 1'b1;
        tx_from_reg   <= bus.local_from;
        tx_to_reg     <= bus.local_to;
      end else if (remote_ack_next) begin
        upd_valid_reg <= 1'b1;
        upd_from_reg  <= bus.remote_from;
        upd_to_reg    <= bus.remote_to;
      end else begin
        if (upd_valid_reg && bus.upd_ready) upd_valid_reg <= 1'b0;
        if (tx_valid_reg && bus.tx_ready)   tx_valid_reg  <= 1'b0;
      end

      if (commit_done && (turn_cnt_reg != TURN_CNT_MAX))
        turn_cnt_reg <= turn_cnt_reg + 10'd1;

      if ((state_next == GAME_OVER) && (state_reg != GAME_OVER)) begin
        game_over_reg  <= 1'b1;
        local_lost_reg <= (state_reg == LOCAL_TURN);
      end
    end
  end

  assign bus.local_ack  = local_ack_next;
  assign bus.remote_ack = remote_ack_next;
  assign bus.upd_valid  = upd_valid_reg;
  assign bus.upd_from   = upd_from_reg;
  assign bus.upd_to     = upd_to_reg;
  assign bus.tx_valid   = tx_valid_reg;
  assign bus.tx_from    = tx_from_reg;
  assign bus.tx_to      = tx_to_reg;

  assign proto_err  = proto_err_next;
  assign your_turn  = your_turn_reg;
  assign turn_cnt   = turn_cnt_reg;
  assign game_over  = game_over_reg;
  assign local_lost = local_lost_reg;

endmodule
